muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock; rst_n, input, 1, asynchronous active-low reset.
REQ-002 start, input, 1, request a new operation; sampled at rising edges of clk.
REQ-003 op_div, input, 1, operation select: 0 = multiply (MULT/MULTU), 1 = divide (DIV/DIVU).
REQ-004 unsign, input, 1, operand signedness: 0 = two's-complement signed, 1 = unsigned.
REQ-005 a, input, 32, multiplicand or dividend.
REQ-006 b, input, 32, multiplier or divisor.
REQ-007 busy, output, 1, operation in progress; the pipeline stalls on it.
REQ-008 done, output, 1, one-cycle pulse; hi/lo have just been updated.
REQ-009 hi, output, 32, HI register: product[63:32] or remainder.
REQ-010 lo, output, 32, LO register: product[31:0] or quotient.

Function
REQ-011 FSM states SHALL be IDLE, CALC and FINISH; busy SHALL be 1 whenever the state is not IDLE.
REQ-012 In IDLE with start=1, the rising edge (E0) SHALL latch a, b, op_div and unsign, load the iteration counter with 31, and enter CALC.
REQ-013 Operands SHALL be converted to magnitudes at accept when unsign=0; result signs SHALL be recorded at accept: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
REQ-014 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; 32 steps at edges E1..E32.
REQ-015 At E32 the counter SHALL reach 0 and the FSM SHALL enter FINISH.
REQ-016 At E33 FINISH SHALL apply sign correction, write hi/lo, assert done for exactly one cycle, and return to IDLE; busy SHALL be high for 33 cycles.
REQ-017 start asserted while busy=1 SHALL be ignored, with no queueing; start in the same cycle the done pulse is visible SHALL be accepted.
REQ-018 hi/lo SHALL hold their value at all times except at the FINISH edge.
REQ-019 Division by zero SHALL take the normal latency and produce hi = a (original, uncorrected) and lo = 32'hFFFFFFFF, for both signed and unsigned.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL produce lo = 0x80000000 and hi = 0.
REQ-021 Changes on a, b, op_div or unsign after accept SHALL NOT affect the result.

Reset
REQ-022 rst_n=0 SHALL immediately, asynchronously force state IDLE, counter 0, busy 0, done 0, hi 0 and lo 0, including in the middle of an operation.
REQ-023 The first rising edge with rst_n=1 SHALL be able to accept start.

Configuration
REQ-024 With MULDIV_FAST_MULT_EN defined, a multiply SHALL go IDLE -> FINISH directly using a single-cycle 64-bit product: busy for 1 cycle, hi/lo written and done pulsed at E1.
REQ-025 Without MULDIV_FAST_MULT_EN, multiply SHALL use the iterative path of REQ-014..REQ-016; divide SHALL be iterative in both builds.

Verification
REQ-026 MULTU with a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; done pulses 33 cycles after accept, or 1 cycle with MULDIV_FAST_MULT_EN.
REQ-027 MULT with a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
REQ-028 DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with a=7, b=2 -> lo=3, hi=1.
REQ-029 DIVU with a=0x00001234, b=0 -> hi=0x00001234, lo=0xFFFFFFFF after 33 busy cycles.
REQ-030 Second start at cycle 10 of a busy DIVU 100/7 -> ignored; result lo=14, hi=2; a single done pulse.
REQ-031 rst_n low at cycle 15 of a DIV -> busy, done, hi and lo are 0 immediately; a new MULTU 3*4 after release -> lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide unit with HI/LO results.
// Signed operands are reduced to magnitudes at accept; signs are reapplied in FINISH.
// Optional build macro: MULDIV_FAST_MULT_EN (single-cycle multiply, IDLE -> FINISH).
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_div,
    input  logic        unsign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_div_q, op_div_d;
    logic        res_neg_q, res_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [31:0] acc_hi_q, acc_hi_d;  // product high half / partial remainder
    logic [31:0] acc_lo_q, acc_lo_d;  // multiplier / dividend shifting into quotient
    logic [31:0] a_orig_q, a_orig_d;  // raw dividend for the divide-by-zero result
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] add_sum, shifted, trial;
    logic [63:0] prod_raw, prod_fix;

    assign a_mag = (!unsign && a[31]) ? -a : a;
    assign b_mag = (!unsign && b[31]) ? -b : b;

    // Next-state, datapath step and result formatting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        a_orig_d  = a_orig_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        add_sum   = '0;
        shifted   = '0;
        trial     = '0;
        prod_raw  = {acc_hi_q, acc_lo_q};
        prod_fix  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_div_d  = op_div;
                    res_neg_d = !unsign && (a[31] ^ b[31]);
                    rem_neg_d = !unsign && a[31];
                    a_orig_d  = a;
                    opnd_d    = b_mag;
                    acc_hi_d  = '0;
                    acc_lo_d  = a_mag;
                    cnt_d     = 5'd31;
                    state_d   = CALC;
`ifdef MULDIV_FAST_MULT_EN
                    if (!op_div) state_d = FINISH;
`endif
                end
            end
            CALC: begin
                if (op_div_q) begin
                    // Restoring step: the 33-bit trial cannot overflow because rem < divisor
                    shifted = {acc_hi_q, acc_lo_q[31]};
                    trial   = shifted - {1'b0, opnd_q};
                    if (!trial[32]) begin
                        acc_hi_d = trial[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b1};
                    end else begin
                        acc_hi_d = shifted[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b0};
                    end
                end else begin
                    add_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
                    acc_hi_d = add_sum[32:1];
                    acc_lo_d = {add_sum[0], acc_lo_q[31:1]};
                end
                if (cnt_q == 5'd0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef MULDIV_FAST_MULT_EN
                if (!op_div_q) prod_raw = {32'b0, opnd_q} * {32'b0, acc_lo_q};
`endif
                if (op_div_q) begin
                    if (opnd_q == '0) begin
                        hi_d = a_orig_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
                        lo_d = res_neg_q ? -acc_lo_q : acc_lo_q;
                    end
                end else begin
                    prod_fix = res_neg_q ? -prod_raw : prod_raw;
                    hi_d     = prod_fix[63:32];
                    lo_d     = prod_fix[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            a_orig_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            a_orig_q  <= a_orig_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
